// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared combinational ALU and returns results over valid/ready.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default is round-robin.
module alu_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  input  logic [NUM_REQ*4-1:0]  req_sel,
  output logic [31:0]           alu_op1,
  output logic [31:0]           alu_op2,
  output logic [3:0]            alu_sel,
  input  logic [31:0]           alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [3:0]        sel_q, sel_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == RESP && rsp_ready) begin
      rr_ptr_d = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sel_d      = sel_q;
    gid_d      = gid_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid && !rst) begin
          req_ready[grant_id] = 1'b1;
          op1_d   = req_op1[32*grant_id +: 32];
          op2_d   = req_op2[32*grant_id +: 32];
          sel_d   = req_sel[4*grant_id +: 4];
          gid_d   = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Codes above COPY1 are illegal and yield a zero result.
        rsp_data_d = (sel_q > 4'd10) ? 32'd0 : alu_out;
        rsp_id_d   = gid_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      gid_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sel_q      <= sel_d;
      gid_q      <= gid_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU sits on the alu_* port and a
// reference model tracks the round-robin pointer and expected results.
module tb_alu_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N*4-1:0]  req_sel;
  logic [31:0]     alu_op1, alu_op2, alu_out;
  logic [3:0]      alu_sel;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {31'd0, $signed(a) < $signed(b)};
      4'd6:    return {31'd0, a < b};
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return 32'($signed(a) >>> b[4:0]);
      4'd10:   return a;
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU; illegal codes produce garbage that the arbiter must discard.
  always_comb begin
    alu_out = (alu_sel > 4'd10) ? 32'hDEADBEEF : alu_ref(alu_op1, alu_op2, alu_sel);
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s);
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
    req_sel[4*i +: 4]   = s;
    req_valid[i]        = 1'b1;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
            4'($urandom_range(0, 15)));
  endtask

  // One arbitration round, starting just after a clock edge with the FSM in IDLE.
  task automatic txn(input int stall, input logic [N-1:0] raise);
    int          g;
    logic [N-1:0] exp_rdy;
    logic [31:0] a, b, exp_d;
    logic [3:0]  s;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
    end
    exp_rdy = (g < 0) ? '0 : N'(1 << g);
    @(negedge clk);
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL grant: req_ready=%b required=%b", req_ready, exp_rdy);
    end
    if (g < 0) begin
      @(posedge clk); #1;
      $display("txn idle: no request, req_ready=%b", req_ready);
      return;
    end
    a = req_op1[32*g +: 32];
    b = req_op2[32*g +: 32];
    s = req_sel[4*g +: 4];
    exp_d = (s > 4'd10) ? 32'd0 : alu_ref(a, b, s);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    for (int i = 0; i < N; i++) if (raise[i]) set_req_rand(i);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== '0 || alu_op1 !== a || alu_op2 !== b || alu_sel !== s) begin
      bad++;
      $display("FAIL exec: rsp_valid=%b req_ready=%b alu=%h/%h/%0d required 0/0/%h/%h/%0d",
               rsp_valid, req_ready, alu_op1, alu_op2, alu_sel, a, b, s);
    end
    @(posedge clk); #1;
    for (int t = 0; t <= stall; t++) begin
      rsp_ready = (t == stall);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'(g) || req_ready !== '0
          || alu_op1 !== a) begin
        bad++;
        $display("FAIL resp: valid=%b data=%h id=%0d req_ready=%b alu_op1=%h required 1/%h/%0d/0/%h",
                 rsp_valid, rsp_data, rsp_id, req_ready, alu_op1, exp_d, g, a);
      end
      @(posedge clk); #1;
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_m = (g + 1) % N;
`endif
    $display("txn grant=%0d op1=%h op2=%h sel=%0d stall=%0d data=%h", g, a, b, s, stall, exp_d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req_rand(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0
        || alu_op1 !== '0 || alu_op2 !== '0 || alu_sel !== '0) begin
      bad++;
      $display("FAIL reset: rdy=%b valid=%b data=%h id=%0d alu=%h/%h/%0d required all zero",
               req_ready, rsp_valid, rsp_data, rsp_id, alu_op1, alu_op2, alu_sel);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m = 0;
    $display("txn reset applied");
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) set_req_rand(i);
    repeat (N) txn(0, '0);
    for (int i = 0; i < N; i++) set_req_rand(i);
    txn(0, '0);
    req_valid = '0;
  endtask

  task automatic test_basic_add();
    set_req(0, 32'd5, 32'd3, 4'd0);
    txn(0, '0);
  endtask

  task automatic test_stall_sra();
    set_req(1, 32'h8000_0000, 32'd4, 4'd9);
    txn(5, N'(4'b1000));
    txn(0, '0);
  endtask

  task automatic test_illegal();
    set_req(2, 32'h1234_5678, 32'h1, 4'd15);
    txn(0, '0);
    for (int i = 0; i < N; i++) set_req_rand(i);
    txn(0, '0);
    req_valid = '0;
  endtask

  task automatic test_idle();
    repeat (3) txn(0, '0);
  endtask

  task automatic test_reset_in_resp();
    for (int i = 0; i < N; i++) set_req_rand(i);
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort: rsp_valid=%b required 1", rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      bad++;
      $display("FAIL abort: rsp_valid=%b req_ready=%b required 0/0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m = 0;
    $display("txn reset during response");
    txn(0, '0);
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req_rand(i);
      end
      if (req_valid == '0) set_req_rand($urandom_range(0, N - 1));
      txn($urandom_range(0, 2), '0);
    end
    req_valid = '0;
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    set_req_rand(0);
    set_req_rand(3);
    repeat (4) txn(0, N'(4'b0001));
    req_valid = '0;
  endtask
`endif

  initial begin
    req_valid = '0;
    req_op1 = '0;
    req_op2 = '0;
    req_sel = '0;
    test_reset();
    test_round_robin();
    test_basic_add();
    test_stall_sra();
    test_illegal();
    test_idle();
    test_reset_in_resp();
    test_random();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
